// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: read-engine state encoding, phase counter width
// and the parameter legality check used by the eFuse blocks.
package efuse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4
    } efuse_rd_state_e;

    localparam int TCNT_W = 4;

    // THD below 2 would sample before the mux-delayed aen has been held off.
    function automatic bit efuse_rd_params_ok(input int nr, input int tsu,
                                              input int taen, input int thd);
        return (nr >= 1) && (nr <= 256) &&
               (tsu >= 1) && (tsu <= 15) &&
               (taen >= 1) && (taen <= 15) &&
               (thd >= 2) && (thd <= 15);
    endfunction

endpackage

// File: rtl/efuse_read_ctrl.sv
// eFuse read engine: walks byte addresses 0..NR-1 with SETUP/PULSE/HOLD
// timing toward efuse_mux and captures each byte into a shadow register file.
module efuse_read_ctrl
    import efuse_pkg::*;
#(
    parameter int NR   = 64,
    parameter int TSU  = 2,
    parameter int TAEN = 3,
    parameter int THD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              abort,
    input  logic              rg_efuse_reg_mode,
    input  logic              busy_write,
    output logic              read_pgmen,
    output logic              read_rden,
    output logic              read_aen,
    output logic [7:0]        read_addr,
    output logic              busy_read,
    input  logic [7:0]        read_rdata,
    output logic [8*NR-1:0]   shadow_data,
    output logic              shadow_valid,
    output logic              load_done
);

    if (!efuse_rd_params_ok(NR, TSU, TAEN, THD)) begin : g_bad_params
        $error("efuse_read_ctrl: illegal NR/TSU/TAEN/THD parameter combination");
    end

    localparam logic [TCNT_W-1:0] TSU_LD    = TCNT_W'(TSU - 1);
    localparam logic [TCNT_W-1:0] TAEN_LD   = TCNT_W'(TAEN - 1);
    localparam logic [TCNT_W-1:0] THD_LD    = TCNT_W'(THD - 1);
    localparam logic [7:0]        LAST_ADDR = 8'(NR - 1);

    efuse_rd_state_e   state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              capture;
    logic              blocked;
    logic [7:0]        shadow_q [NR];

    assign blocked = rg_efuse_reg_mode | busy_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Phase counter loads duration-1 on entry and the phase ends when it hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_req && !abort) begin
                    valid_d = 1'b0;
                    addr_d  = '0;
                    if (blocked) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = TSU_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!blocked) begin
                    state_d = ST_SETUP;
                    cnt_d   = TSU_LD;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = TAEN_LD;
                end else begin
                    cnt_d = cnt_q - TCNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = THD_LD;
                end else begin
                    cnt_d = cnt_q - TCNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = TSU_LD;
                        addr_d  = addr_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - TCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        read_rden = 1'b0;
        read_aen  = 1'b0;
        busy_read = 1'b0;
        read_addr = '0;
        case (state_q)
            ST_SETUP, ST_HOLD: begin
                read_rden = 1'b1;
                busy_read = 1'b1;
                read_addr = addr_q;
            end
            ST_PULSE: begin
                read_rden = 1'b1;
                read_aen  = 1'b1;
                busy_read = 1'b1;
                read_addr = addr_q;
            end
            default: ;
        endcase
    end

    // Byte-write shadow register file; a byte changes only on its own capture.
    for (genvar i = 0; i < NR; i++) begin : g_shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q[i] <= '0;
            end else if (capture && (addr_q == 8'(i))) begin
                shadow_q[i] <= read_rdata;
            end
        end
        assign shadow_data[8*i +: 8] = shadow_q[i];
    end

    assign read_pgmen   = 1'b0;
    assign shadow_valid = valid_q;
    assign load_done    = done_q;

endmodule

// File: tb/tb_efuse_read_ctrl.sv
// Directed bench for efuse_read_ctrl with NR=4, TSU=2, TAEN=3, THD=2 and a
// macro model returning addr^8'hA5 one cycle after the efuse_mux register.
module tb_efuse_read_ctrl;

    localparam int NR    = 4;
    localparam int PER   = 7;   // TSU+TAEN+THD
    localparam int BUSY  = 28;  // NR*PER
    localparam int AENS  = 12;  // NR*TAEN
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        abort = 1'b0;
    logic        rg_efuse_reg_mode = 1'b0;
    logic        busy_write = 1'b0;
    logic        read_pgmen, read_rden, read_aen, busy_read;
    logic [7:0]  read_addr;
    logic [7:0]  read_rdata = 8'h00;
    logic [7:0]  mux_addr = 8'h00;
    logic [31:0] shadow_data;
    logic        shadow_valid, load_done;

    int checks = 0;
    int errors = 0;
    int pgmen_bad = 0;

    efuse_read_ctrl #(.NR(NR), .TSU(2), .TAEN(3), .THD(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .abort(abort),
        .rg_efuse_reg_mode(rg_efuse_reg_mode), .busy_write(busy_write),
        .read_pgmen(read_pgmen), .read_rden(read_rden), .read_aen(read_aen),
        .read_addr(read_addr), .busy_read(busy_read), .read_rdata(read_rdata),
        .shadow_data(shadow_data), .shadow_valid(shadow_valid), .load_done(load_done)
    );

    always #5 clk = ~clk;

    // efuse_mux register stage followed by the macro's one-cycle read.
    always @(posedge clk) begin
        mux_addr   <= read_addr;
        read_rdata <= mux_addr ^ 8'hA5;
    end

    always @(negedge clk) if (read_pgmen !== 1'b0) pgmen_bad++;

    typedef struct {
        string       name;
        logic        bw;
        logic        rm;
        int          blk;
        logic        rereq;
        int          exp_busy;
        int          exp_aen;
        logic [31:0] exp_shadow;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_load(input vec_t v);
        int n;
        int aen_cnt;
        int addr_bad;
        int blk_bad;
        int done_cnt;
        aen_cnt = 0; addr_bad = 0; blk_bad = 0; done_cnt = 0; n = 0;
        busy_write = v.bw;
        rg_efuse_reg_mode = v.rm;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk({v.name, ".valid_clr"}, shadow_valid, 1'b0);
        for (int i = 0; i < v.blk; i++) begin
            if (busy_read || read_rden) blk_bad++;
            if (i == v.blk - 1) begin
                busy_write = 1'b0;
                rg_efuse_reg_mode = 1'b0;
            end
            tick();
        end
        chk({v.name, ".blocked"}, blk_bad, 0);
        chk({v.name, ".start"}, {busy_read, read_rden, read_addr}, {1'b1, 1'b1, 8'h00});
        while (busy_read && n < BOUND) begin
            if (read_aen) aen_cnt++;
            if (read_addr !== 8'(n / PER)) addr_bad++;
            if (load_done) done_cnt++;
            load_req = v.rereq && (n == 5);
            n++;
            tick();
        end
        load_req = 1'b0;
        if (n >= BOUND) begin
            errors++;
            checks++;
            $display("FAIL %s.timeout busy_read still high after %0d cycles", v.name, n);
        end
        chk({v.name, ".busy_cycles"}, n, v.exp_busy);
        chk({v.name, ".aen_cycles"}, aen_cnt, v.exp_aen);
        chk({v.name, ".addr_seq"}, addr_bad, 0);
        chk({v.name, ".done_at_end"}, {load_done, shadow_valid}, 2'b11);
        chk({v.name, ".shadow"}, shadow_data, v.exp_shadow);
        if (load_done) done_cnt++;
        tick();
        if (load_done) done_cnt++;
        chk({v.name, ".done_pulses"}, done_cnt, 1);
        chk({v.name, ".idle_after"}, busy_read, 1'b0);
    endtask

    initial begin
        vec_t fin;
        int cnt;
        vecs[0] = '{"basic",      1'b0, 1'b0, 0,  1'b0, BUSY, AENS, 32'hA6A7A4A5};
        vecs[1] = '{"busy_write", 1'b1, 1'b0, 5,  1'b0, BUSY, AENS, 32'hA6A7A4A5};
        vecs[2] = '{"reg_mode",   1'b0, 1'b1, 10, 1'b0, BUSY, AENS, 32'hA6A7A4A5};
        vecs[3] = '{"rereq",      1'b0, 1'b0, 0,  1'b1, BUSY, AENS, 32'hA6A7A4A5};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ctrl", {busy_read, read_rden, read_aen, read_pgmen}, 4'b0000);
        chk("rst.addr", read_addr, 8'h00);
        chk("rst.shadow", shadow_data, 32'h0);
        chk("rst.flags", {shadow_valid, load_done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            run_load(vecs[k]);
            repeat (2) tick();
        end

        // load_req and abort together in IDLE: no start, valid flag kept
        load_req = 1'b1;
        abort = 1'b1;
        tick();
        load_req = 1'b0;
        abort = 1'b0;
        chk("req_abort.busy", {busy_read, read_rden}, 2'b00);
        repeat (3) tick();
        chk("req_abort.still_idle", busy_read, 1'b0);
        chk("req_abort.valid", shadow_valid, 1'b1);

        // Reset during byte 1 HOLD
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        repeat (12) tick();
        chk("midrst.in_hold", {read_rden, read_aen, read_addr}, {1'b1, 1'b0, 8'h01});
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.ctrl", {busy_read, read_rden, read_aen, read_addr}, 11'h0);
        chk("midrst.shadow", shadow_data, 32'h0);
        chk("midrst.flags", {shadow_valid, load_done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Abort during byte 2 PULSE
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        repeat (16) tick();
        chk("abort.in_pulse", {read_aen, read_addr}, {1'b1, 8'h02});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.ctrl", {busy_read, read_rden, read_aen}, 3'b000);
        chk("abort.valid", shadow_valid, 1'b0);
        chk("abort.kept", shadow_data, 32'h0000A4A5);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (load_done || busy_read) cnt++;
            tick();
        end
        chk("abort.no_done", cnt, 0);

        fin = vecs[0];
        fin.name = "reload";
        run_load(fin);

        chk("pgmen.never", pgmen_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/efuse_read_ctrl.md
# efuse_read_ctrl

Hardware read engine for the eFuse macro: on a load request it walks eFuse byte addresses 0..NR-1, generates the rden/aen read timing, captures each returned byte into a shadow register array, and flags completion. It sits directly upstream of efuse_mux. It drives efuse_mux's read_* inputs and busy_read, and consumes read_rdata. Because efuse_mux registers control signals by one cycle, the hold phase of this engine absorbs that delay.

## Interface
- NR, 64: number of bytes loaded per request, 1..256
- TSU, 2: rden/addr setup cycles before aen, 1..15
- TAEN, 3: aen high cycles, 1..15
- THD, 2: hold cycles after aen before sampling/advance, 2..15; ≥2 covers the mux register stage
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- load_req  in  1  single-cycle load request pulse
- abort  in  1  single-cycle abort pulse
- rg_efuse_reg_mode  in  1  SW direct-access mode active; blocks start
- busy_write  in  1  program engine owns the macro; blocks start
- read_pgmen  out  1  constant 0
- read_rden  out  1  read enable to efuse_mux
- read_aen  out  1  access strobe to efuse_mux
- read_addr  out  8  byte address to efuse_mux
- busy_read  out  1  engine owns the macro
- read_rdata  in  8  byte returned through efuse_mux
- shadow_data  out  8*NR  loaded bytes; byte i at [8i+7:8i]
- shadow_valid  out  1  complete load since last request
- load_done  out  1  single-cycle pulse at completion

## Operation
- States: IDLE, WAIT, SETUP, PULSE, HOLD.
- IDLE: outputs low, busy_read=0. When load_req=1:
  - go to SETUP if rg_efuse_reg_mode=0 and busy_write=0;
  - otherwise go to WAIT.
  - Either way: shadow_valid←0 and addr←0.
- WAIT: busy_read=0. Go to SETUP in the first cycle that rg_efuse_reg_mode=0 and busy_write=0.
- SETUP: rden=1, aen=0, busy_read=1, for TSU cycles.
- PULSE: rden=1, aen=1, for TAEN cycles.
- HOLD: rden=1, aen=0, for THD cycles.
  - On the clock edge ending the last HOLD cycle, read_rdata is written to shadow byte[addr].
  - If addr==NR-1: go to IDLE, set shadow_valid=1, pulse load_done.
  - Otherwise: addr+1, go to SETUP.
- read_addr is valid and stable throughout SETUP, PULSE and HOLD; it changes only at a byte boundary.
- Phase counter is 4 bits; it reloads on every state entry. The addr counter is 8 bits, with no wrap beyond NR-1.
- load_req outside IDLE is ignored; it is not queued.
- abort in any non-IDLE state: go to IDLE next cycle and drop rden/aen/busy_read. shadow_valid stays 0, no load_done, and bytes already written remain. abort in IDLE: no effect.
- Simultaneous load_req and abort in IDLE: abort wins, stay IDLE, shadow_valid unchanged.
- A change in rg_efuse_reg_mode or busy_write after start does not stall the sequence. Arbitration beyond start belongs to efuse_mux.

## Timing
- Reset values:
  - state IDLE, addr 0;
  - all outputs 0, including shadow_data, shadow_valid, load_done and read_pgmen.
- Reset mid-load clears everything immediately (async).
- Start: load_req sampled at edge k with no block → busy_read=1, rden=1 and read_addr=0 from cycle k+1.
- Per-byte duration: TSU+TAEN+THD cycles.
- Full load: NR*(TSU+TAEN+THD) cycles of busy_read.
- Completion: load_done and shadow_valid rise in the cycle busy_read falls. shadow byte NR-1 is visible in that same cycle.
- The macro sees aen one cycle late (mux register). Sampling at the end of HOLD gives at least THD-1 cycles after the macro's last aen cycle.

## Structure
- Shared package efuse_pkg holds:
  - state enum efuse_rd_state_e;
  - localparam TCNT_W=4;
  - parameter range checks.
- efuse_mux also imports efuse_pkg.
- Single module; no sub-module. The shadow array is a simple byte-write register file, generated inline.

## Test plan
Bench settings: NR=4, TSU=2, TAEN=3, THD=2. Macro model returns addr^8'hA5 one cycle after efuse_mux.
- Basic load: load_req pulse → busy_read high for 28 cycles, aen high 3 cycles per byte, read_addr 0,1,2,3. Then shadow_data=32'hA6A7A4A5, shadow_valid=1, one load_done pulse.
- Blocked start: load_req while busy_write=1 → WAIT, no rden. busy_write drops → SETUP next cycle, full 28-cycle load completes.
- Reg mode: load_req with rg_efuse_reg_mode=1 for 10 cycles → no busy_read. Load starts the cycle after it clears.
- Abort at byte 2 PULSE → rden/aen/busy_read 0 next cycle, shadow_valid=0, bytes 0..1 kept, no load_done.
- Reset mid-load (byte 1 HOLD) → all outputs 0 immediately. A new load_req after reset reloads 32'hA6A7A4A5.
- Re-request and pgmen:
  - load_req during busy → ignored, total still 28 cycles;
  - load_req+abort together in IDLE → no start;
  - read_pgmen stays 0 throughout.
